// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and scoreboard response signals for hazard_scoreboard.
// master drives the decoded instruction; slave is the scoreboard itself.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic        flush;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        single_src;
  logic        mem_w_en;
  logic [4:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        forward_en;
  logic        hazard_detected;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  modport master (
    output id_valid, flush, src1, src2, single_src, mem_w_en, dest, wb_en, mem_r_en,
           forward_en,
    input  hazard_detected, busy_mask, stall_cycles
  );

  modport slave (
    input  id_valid, flush, src1, src2, single_src, mem_w_en, dest, wb_en, mem_r_en,
           forward_en,
    output hazard_detected, busy_mask, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard: per-register writeback countdown, load flag, stall detection
// and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int unsigned WB_LAT    = 2,
  // Test hook: freezes the countdown while stalled so a conflict can be held indefinitely.
  parameter bit          TEST_HOLD = 1'b0
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);
  localparam logic [1:0] WbLat = 2'(WB_LAT);

  logic [31:0][1:0] cnt_q, cnt_d;
  logic [31:0]      ld_q, ld_d;
  logic [15:0]      stall_q, stall_d;
  logic             src2_read, conf1, conf2, hazard, issue, hold;

  always_comb begin
    src2_read = ~sb.single_src | sb.mem_w_en;
    if (sb.forward_en) begin
      // Only a load issued in the immediately preceding cycle cannot be forwarded.
      conf1 = (sb.src1 != 5'd0) && ld_q[sb.src1] && (cnt_q[sb.src1] == WbLat);
      conf2 = (sb.src2 != 5'd0) && ld_q[sb.src2] && (cnt_q[sb.src2] == WbLat);
    end else begin
      conf1 = (sb.src1 != 5'd0) && (cnt_q[sb.src1] != 2'd0);
      conf2 = (sb.src2 != 5'd0) && (cnt_q[sb.src2] != 2'd0);
    end
    hazard = sb.id_valid & ~sb.flush & (conf1 | (src2_read & conf2));
    issue  = sb.id_valid & ~sb.flush & ~hazard;
    hold   = TEST_HOLD & hazard;
  end

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != 2'd0 && !hold) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
        if (cnt_q[r] == 2'd1) begin
          ld_d[r] = 1'b0;
        end
      end
    end
    if (issue && sb.wb_en && sb.dest != 5'd0) begin
      cnt_d[sb.dest] = WbLat;
      ld_d[sb.dest]  = sb.mem_r_en;
    end
    cnt_d[0] = 2'd0;
    ld_d[0]  = 1'b0;
    stall_d  = (hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ld_q    <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    sb.busy_mask = '0;
    for (int r = 1; r < 32; r++) begin
      sb.busy_mask[r] = (cnt_q[r] != 2'd0);
    end
  end

  assign sb.hazard_detected = hazard;
  assign sb.stall_cycles    = stall_q;
endmodule
